raster_scheduler: RTL and testbench
===================================

# raster_scheduler

Dispatches triangles from the vertex/setup stage to a pool of `NUM_UNITS` rasterizer units. It buffers incoming triangles in a small FIFO and hands each one to a free unit in round-robin order, using a start/busy/done handshake. It also counts completed triangles and flags units that fail to acknowledge a start. It sits between the triangle producer and the rasterizer array in the graphics pipeline.

## Interface
- `NUM_UNITS`, 2: number of rasterizer units, 1..8
- `FIFO_DEPTH`, 4: triangle buffer depth, power of two, ≥2
- `ACK_TIMEOUT`, 16: cycles to wait for `unit_busy` after a start
- `clk`  in  1: clock; everything is on the rising edge
- `rst`  in  1: reset, asynchronous, active-high
- `in_valid`  in  1: producer offers a triangle
- `in_ready`  out  1: scheduler can accept a triangle (`!fifo_full`)
- `in_p1`, `in_p2`, `in_p3`  in  32×3 each: vertex x, y, z
- `unit_start`  out  NUM_UNITS: one-hot, one-cycle start pulse
- `unit_p1`, `unit_p2`, `unit_p3`  out  32×3 each: triangle broadcast to all units, valid while `unit_start` is high
- `unit_busy`  in  NUM_UNITS: unit is working
- `unit_done`  in  NUM_UNITS: one-cycle completion pulse per unit
- `idle`  out  1: FIFO empty, FSM in IDLE, no pending units
- `tri_count`  out  16: completed triangles; wraps 0xFFFF→0
- `timeout_err`  out  1: sticky; cleared only by `rst`

## Operation
- **Push:** `in_valid && in_ready` writes the triangle at the FIFO tail. `in_ready = !full`, so a push can never happen when the FIFO is full.
- **Unit free:** unit i is free when `!unit_busy[i] && !pending[i]`.
- **FSM states:** IDLE, ISSUE, ACK.
- **IDLE:** if the FIFO is non-empty and any unit is free, pick a grant g by round-robin.
  - The search starts at `(last_grant+1) mod NUM_UNITS`.
  - After reset `last_grant = NUM_UNITS-1`, so unit 0 is granted first.
  - Latch g, update `last_grant`, go to ISSUE. Otherwise stay in IDLE.
- **ISSUE (exactly 1 cycle):**
  - `unit_start[g]=1`; `unit_p*` = FIFO head.
  - Pop the FIFO at the end of the cycle; set `pending[g]`.
  - Go to ACK.
- **ACK:**
  - `unit_p*` holds the last issued triangle.
  - Wait for `unit_busy[g]=1`, then go to IDLE.
  - A cycle counter starts at 1 on entry. If `ACK_TIMEOUT` cycles pass without busy: set `timeout_err`, clear `pending[g]`, go to IDLE. The triangle is dropped, not counted, and not retried.
  - A `unit_done[g]` seen in ACK also counts as the acknowledge and ends ACK.
- **Completion:** `unit_done[i] && pending[i]` clears `pending[i]` and increments `tri_count`.
  - Several done pulses in one cycle add their popcount.
  - A done pulse with `!pending[i]` is ignored.
- **Same-cycle set/clear:** if `pending[g]` is set and cleared in the same cycle (start and done together on g), the clear wins.
- **Push during ISSUE:** writes the tail normally. Push and pop in the same cycle leave the count unchanged.

## Timing
- **Reset values:** `in_ready=1`, `unit_start=0`, `unit_p*=0`, `idle=1`, `tri_count=0`, `timeout_err=0`. Also FIFO empty, `pending=0`, FSM in IDLE.
- **Reset mid-operation:** `rst` asserted at any point (including during ISSUE/ACK) returns everything to the reset values immediately. FIFO contents are discarded; in-flight units are forgotten.
- **Latency:** push accepted in cycle N with a unit free → `unit_start` is high in cycle N+2.
- **Back-to-back issues:** one every 3 cycles at best (IDLE, ISSUE, ACK with immediate busy).
- **`unit_p*`:** registered; changes only on entry to ISSUE.
- **`idle`:** combinational from registered state.

## Structure
- **Package `raster_pkg`:**
  - `vertex_t` (`logic [31:0]` ×3)
  - `triangle_t` (struct of p1, p2, p3)
  - `sched_state_t` enum {IDLE, ISSUE, ACK}
  - `TRI_COUNT_W = 16`
- **Sub-module `tri_fifo`:** synchronous FIFO of `triangle_t`.
  - Parameter `DEPTH`.
  - Ports: push, pop, head, full, empty, count.
  - Pointers one bit wider than the index, for the full/empty test.

## Test plan
- Reset, then push one triangle (p1={1,2,3}, p2={4,5,6}, p3={7,8,9}) with both units free → `unit_start=2'b01` in cycle N+2, `unit_p1={1,2,3}`; busy in the next cycle → IDLE; done pulse → `tri_count=1`, `idle=1`.
- Push 4 triangles, hold `unit_busy=0` until each start, then busy → starts alternate 01, 10, 01, 10; fifth push while full is stalled (`in_ready=0`) until the first pop.
- Unit 1 never raises busy → after 16 ACK cycles `timeout_err=1`, `pending[1]=0`, the next triangle goes to unit 0, `tri_count` unchanged.
- Both units pulse done in the same cycle → `tri_count` +2. A spurious done on a non-pending unit → no change.
- Assert `rst` during ACK with 3 triangles queued → all outputs at reset values, `idle=1`, no `unit_start` until a new push.
- `tri_count` preloaded near the wrap (run 65 536 completions) → wraps to 0.

Source files
------------

// File: rtl/raster_pkg.sv
// rtl/raster_pkg.sv - shared triangle types and scheduler state encoding
package raster_pkg;

    typedef logic [2:0][31:0] vertex_t;

    typedef struct packed {
        vertex_t p1;
        vertex_t p2;
        vertex_t p3;
    } triangle_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ACK
    } sched_state_t;

    localparam int TRI_COUNT_W = 16;

endpackage

// File: rtl/tri_fifo.sv
// rtl/tri_fifo.sv - synchronous triangle FIFO with wrap-bit pointers
module tri_fifo
    import raster_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  triangle_t                push_data,
    input  logic                     pop,
    output triangle_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    triangle_t     mem_q [DEPTH];
    triangle_t     mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    // Same index with differing wrap bits means the writer lapped the reader.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign count = wr_ptr_q - rd_ptr_q;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/raster_scheduler.sv
// rtl/raster_scheduler.sv - round-robin triangle dispatch to rasterizer units
module raster_scheduler
    import raster_pkg::*;
#(
    parameter int NUM_UNITS   = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [95:0]             in_p1,
    input  logic [95:0]             in_p2,
    input  logic [95:0]             in_p3,
    output logic [NUM_UNITS-1:0]    unit_start,
    output logic [95:0]             unit_p1,
    output logic [95:0]             unit_p2,
    output logic [95:0]             unit_p3,
    input  logic [NUM_UNITS-1:0]    unit_busy,
    input  logic [NUM_UNITS-1:0]    unit_done,
    output logic                    idle,
    output logic [TRI_COUNT_W-1:0]  tri_count,
    output logic                    timeout_err
);

    localparam int GW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    sched_state_t             state_q, state_d;
    logic [GW-1:0]            grant_q, grant_d;
    logic [GW-1:0]            last_grant_q, last_grant_d;
    logic [NUM_UNITS-1:0]     pending_q, pending_d;
    logic [CW-1:0]            ack_cnt_q, ack_cnt_d;
    logic [TRI_COUNT_W-1:0]   tri_count_q, tri_count_d;
    logic                     timeout_q, timeout_d;
    triangle_t                unit_tri_q, unit_tri_d;

    logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    triangle_t                fifo_head, in_tri;
    logic [NUM_UNITS-1:0]     free, set_mask, drop_mask, done_hit;
    logic [GW-1:0]            pick;
    logic                     found;
    int                       idx;

    assign in_tri    = '{p1: in_p1, p2: in_p2, p3: in_p3};
    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && !fifo_full;

    tri_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (in_tri),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        ack_cnt_d    = ack_cnt_q;
        timeout_d    = timeout_q;
        unit_tri_d   = unit_tri_q;
        unit_start   = '0;
        fifo_pop     = 1'b0;
        set_mask     = '0;
        drop_mask    = '0;
        found        = 1'b0;
        pick         = '0;
        idx          = 0;
        free         = ~unit_busy & ~pending_q;

        case (state_q)
            IDLE: begin
                for (int k = 0; k < NUM_UNITS; k++) begin
                    idx = int'(last_grant_q) + 1 + k;
                    if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
                    if (!found && free[idx]) begin
                        found = 1'b1;
                        pick  = GW'(idx);
                    end
                end
                if (!fifo_empty && found) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    unit_tri_d   = fifo_head;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                unit_start[grant_q] = 1'b1;
                fifo_pop            = 1'b1;
                set_mask[grant_q]   = 1'b1;
                ack_cnt_d           = CW'(1);
                state_d             = ACK;
            end
            ACK: begin
                if (unit_busy[grant_q] || unit_done[grant_q]) begin
                    state_d = IDLE;
                end else if (ack_cnt_q == CW'(ACK_TIMEOUT)) begin
                    // Unacknowledged triangle is dropped; the unit is released.
                    timeout_d          = 1'b1;
                    drop_mask[grant_q] = 1'b1;
                    state_d            = IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A done arriving with its own start retires that start (clear wins).
        done_hit    = unit_done & (pending_q | set_mask);
        pending_d   = (pending_q | set_mask) & ~done_hit & ~drop_mask;
        tri_count_d = tri_count_q;
        for (int i = 0; i < NUM_UNITS; i++) begin
            tri_count_d = tri_count_d + TRI_COUNT_W'(done_hit[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_UNITS - 1);
            pending_q    <= '0;
            ack_cnt_q    <= '0;
            tri_count_q  <= '0;
            timeout_q    <= 1'b0;
            unit_tri_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
            ack_cnt_q    <= ack_cnt_d;
            tri_count_q  <= tri_count_d;
            timeout_q    <= timeout_d;
            unit_tri_q   <= unit_tri_d;
        end
    end

    assign unit_p1     = unit_tri_q.p1;
    assign unit_p2     = unit_tri_q.p2;
    assign unit_p3     = unit_tri_q.p3;
    assign idle        = (fifo_count == '0) && (state_q == IDLE) && (pending_q == '0);
    assign tri_count   = tri_count_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_raster_scheduler.sv
// tb/tb_raster_scheduler.sv - directed scoreboard bench for raster_scheduler
module tb_raster_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] in_p1, in_p2, in_p3;
    logic [1:0]  unit_start;
    logic [95:0] unit_p1, unit_p2, unit_p3;
    logic [1:0]  unit_busy;
    logic [1:0]  unit_done;
    logic        idle;
    logic [15:0] tri_count;
    logic        timeout_err;

    typedef struct {
        int          unit_idx;
        logic [95:0] p1;
        logic [95:0] p2;
        logic [95:0] p3;
    } exp_t;

    exp_t sb[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    raster_scheduler #(.NUM_UNITS(2), .FIFO_DEPTH(4), .ACK_TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_p1       (in_p1),
        .in_p2       (in_p2),
        .in_p3       (in_p3),
        .unit_start  (unit_start),
        .unit_p1     (unit_p1),
        .unit_p2     (unit_p2),
        .unit_p3     (unit_p3),
        .unit_busy   (unit_busy),
        .unit_done   (unit_done),
        .idle        (idle),
        .tri_count   (tri_count),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] vtx(input int b);
        return {32'(b), 32'(b + 1), 32'(b + 2)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        unit_busy = '0;
        unit_done = '0;
        in_p1     = '0;
        in_p2     = '0;
        in_p3     = '0;
        sb.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input int base, input int u);
        int n = 0;
        in_p1    = vtx(base);
        in_p2    = vtx(base + 3);
        in_p3    = vtx(base + 6);
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("push_ready", 96'(in_ready), 96'(1));
        tick();
        in_valid = 1'b0;
        sb.push_back('{u, vtx(base), vtx(base + 3), vtx(base + 6)});
    endtask

    task automatic expect_start(input int budget, input string tag);
        int   n = 0;
        exp_t e;
        while (unit_start == 2'b00 && n < budget) begin
            tick();
            n++;
        end
        vec_cnt++;
        assert (sb.size() > 0) else begin
            err_cnt++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_start"}, 96'(unit_start), 96'(1 << e.unit_idx));
            check({tag, "_p1"}, unit_p1, e.p1);
            check({tag, "_p2"}, unit_p2, e.p2);
            check({tag, "_p3"}, unit_p3, e.p3);
        end
    endtask

    task automatic ack_unit(input int u);
        unit_busy[u] = 1'b1;
        tick();
        tick();
    endtask

    task automatic done_units(input logic [1:0] m);
        unit_busy = unit_busy & ~m;
        unit_done = m;
        tick();
        unit_done = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts;
        rst       = 1'b1;
        in_valid  = 1'b0;
        unit_busy = '0;
        unit_done = '0;
        in_p1     = '0;
        in_p2     = '0;
        in_p3     = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_in_ready", 96'(in_ready), 96'(1));
        check("rst_start", 96'(unit_start), 96'(0));
        check("rst_p1", unit_p1, 96'(0));
        check("rst_idle", 96'(idle), 96'(1));
        check("rst_count", 96'(tri_count), 96'(0));
        check("rst_timeout", 96'(timeout_err), 96'(0));

        // single triangle, N+2 latency, completion
        push(1, 0);
        tick();
        expect_start(0, "t1");
        ack_unit(0);
        check("t1_idle_pending", 96'(idle), 96'(0));
        done_units(2'b01);
        check("t1_count", 96'(tri_count), 96'(1));
        check("t1_idle", 96'(idle), 96'(1));

        // fill FIFO with both units externally busy, then round-robin drain
        do_reset();
        unit_busy = 2'b11;
        push(11, 0);
        push(21, 1);
        push(31, 0);
        push(41, 1);
        check("t2_full", 96'(in_ready), 96'(0));
        in_p1    = vtx(51);
        in_p2    = vtx(54);
        in_p3    = vtx(57);
        in_valid = 1'b1;
        tick();
        check("t2_stall", 96'(in_ready), 96'(0));
        unit_busy = 2'b00;
        tick();
        expect_start(0, "t2a");
        unit_busy = 2'b01;
        tick();
        check("t2_ready_after_pop", 96'(in_ready), 96'(1));
        tick();
        in_valid = 1'b0;
        sb.push_back('{0, vtx(51), vtx(54), vtx(57)});
        tick();
        expect_start(0, "t2b");
        ack_unit(1);
        done_units(2'b01);
        expect_start(5, "t2c");
        ack_unit(0);
        done_units(2'b10);
        expect_start(5, "t2d");
        ack_unit(1);
        done_units(2'b01);
        expect_start(5, "t2e");
        ack_unit(0);
        check("t2_count3", 96'(tri_count), 96'(3));
        done_units(2'b11);
        check("t2_count5", 96'(tri_count), 96'(5));
        check("t2_idle", 96'(idle), 96'(1));

        // unit 1 never acknowledges
        do_reset();
        push(61, 0);
        tick();
        expect_start(0, "t3a");
        ack_unit(0);
        done_units(2'b01);
        push(71, 1);
        tick();
        expect_start(0, "t3b");
        repeat (16) tick();
        check("t3_no_timeout_yet", 96'(timeout_err), 96'(0));
        tick();
        check("t3_timeout", 96'(timeout_err), 96'(1));
        check("t3_idle", 96'(idle), 96'(1));
        check("t3_count", 96'(tri_count), 96'(1));
        push(81, 0);
        tick();
        expect_start(0, "t3c");
        ack_unit(0);
        done_units(2'b01);
        check("t3_count2", 96'(tri_count), 96'(2));
        unit_done = 2'b10;
        tick();
        unit_done = 2'b00;
        check("t3_spurious", 96'(tri_count), 96'(2));
        check("t3_sticky", 96'(timeout_err), 96'(1));

        // reset while in ACK with three triangles queued
        do_reset();
        unit_busy = 2'b10;
        push(91, 0);
        push(101, 0);
        push(111, 0);
        push(121, 0);
        check("t4_busy", 96'(idle), 96'(0));
        rst = 1'b1;
        #1;
        check("t4_in_ready", 96'(in_ready), 96'(1));
        check("t4_start", 96'(unit_start), 96'(0));
        check("t4_p1", unit_p1, 96'(0));
        check("t4_idle", 96'(idle), 96'(1));
        check("t4_count", 96'(tri_count), 96'(0));
        check("t4_timeout", 96'(timeout_err), 96'(0));
        tick();
        rst       = 1'b0;
        unit_busy = 2'b00;
        sb.delete();
        starts = 0;
        repeat (5) begin
            tick();
            if (unit_start != 2'b00) starts++;
        end
        check("t4_no_start", 96'(starts), 96'(0));
        push(131, 0);
        tick();
        expect_start(0, "t4");

        // counter wrap
        do_reset();
        push(141, 0);
        tick();
        expect_start(0, "t5");
        ack_unit(0);
        force dut.tri_count_q = 16'hFFFF;
        #1;
        release dut.tri_count_q;
        check("t5_preload", 96'(tri_count), 96'(16'hFFFF));
        done_units(2'b01);
        check("t5_wrap", 96'(tri_count), 96'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
